// File: rtl/gpio_mmio_port.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : gpio_mmio_port                                            |
// | Description : Memory-mapped GPIO port with an OUT register, a           |
// |               synchronized and debounced IN register, rising-edge       |
// |               capture with write-1-to-clear, an interrupt mask and a    |
// |               registered level interrupt.                               |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module gpio_mmio_port #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [1:0]       addr_i,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o,
   input  logic [WIDTH-1:0] GPIO_i,
   output logic [WIDTH-1:0] GPIO_o,
   output logic             irq_o
);

   localparam logic [1:0] ADDR_OUT  = 2'd0;
   localparam logic [1:0] ADDR_IN   = 2'd1;
   localparam logic [1:0] ADDR_EDGE = 2'd2;
   localparam logic [1:0] ADDR_MASK = 2'd3;

   localparam logic [7:0] CNT_MAX  = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0] CNT_LOAD = 8'(DEBOUNCE_CYCLES - 1);

   // Input conditioning state
   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync_stable;
   logic [WIDTH-1:0] sync_prev;
   logic [7:0]       stable_cnt;
   logic [WIDTH-1:0] in_reg;

   // Register file state
   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] mask_reg;
   logic [WIDTH-1:0] edge_reg;
   logic             irq_reg;
   logic [31:0]      rdata_reg;

   // Combinational helpers
   logic             sync_changed;
   logic             in_load;
   logic [WIDTH-1:0] in_next;
   logic [WIDTH-1:0] edge_rise;
   logic [WIDTH-1:0] edge_clear;
   logic [31:0]      read_mux;
   logic             wr_out;
   logic             wr_mask;
   logic             wr_edge;

   // Upper write-data bits carry no state; fold them into a sink.
   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic unused_wdata_hi;
         assign unused_wdata_hi = ^wdata_i[31:WIDTH];
      end
   endgenerate

   // Debounce decision: the whole input vector must be unchanged for the
   // full stable window before it is accepted into IN.
   always_comb begin
      sync_changed = (sync_stable != sync_prev);
      in_load      = !sync_changed && (stable_cnt == CNT_LOAD);
      in_next      = in_load ? sync_stable : in_reg;
      edge_rise    = in_next & ~in_reg;
   end

   // Bus decode; the edge-capture clear mask only exists during an EDGE write.
   always_comb begin
      wr_out     = we_i && (addr_i == ADDR_OUT);
      wr_mask    = we_i && (addr_i == ADDR_MASK);
      wr_edge    = we_i && (addr_i == ADDR_EDGE);
      edge_clear = wr_edge ? wdata_i[WIDTH-1:0] : '0;
   end

   // Read multiplexer, zero-extended to the bus width.
   always_comb begin
      read_mux = '0;
      case (addr_i)
         ADDR_OUT:  read_mux[WIDTH-1:0] = out_reg;
         ADDR_IN:   read_mux[WIDTH-1:0] = in_reg;
         ADDR_EDGE: read_mux[WIDTH-1:0] = edge_reg;
         ADDR_MASK: read_mux[WIDTH-1:0] = mask_reg;
         default:   read_mux            = '0;
      endcase
   end

   // Two-flop synchronizer, previous-value tracker, stable counter and IN.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_meta   <= '0;
         sync_stable <= '0;
         sync_prev   <= '0;
         stable_cnt  <= '0;
         in_reg      <= '0;
      end else begin
         sync_meta   <= GPIO_i;
         sync_stable <= sync_meta;
         sync_prev   <= sync_stable;
         if (sync_changed) begin
            stable_cnt <= '0;
         end else if (stable_cnt != CNT_MAX) begin
            stable_cnt <= stable_cnt + 8'd1;
         end
         in_reg <= in_next;
      end
   end

   // Software-visible registers, interrupt and registered read data.
   // A new rising edge overrides a simultaneous write-1-to-clear.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_reg   <= '0;
         mask_reg  <= '0;
         edge_reg  <= '0;
         irq_reg   <= 1'b0;
         rdata_reg <= '0;
      end else begin
         if (wr_out) begin
            out_reg <= wdata_i[WIDTH-1:0];
         end
         if (wr_mask) begin
            mask_reg <= wdata_i[WIDTH-1:0];
         end
         edge_reg <= (edge_reg & ~edge_clear) | edge_rise;
         irq_reg  <= |(edge_reg & mask_reg);
         if (re_i) begin
            rdata_reg <= read_mux;
         end
      end
   end

   assign GPIO_o  = out_reg;
   assign irq_o   = irq_reg;
   assign rdata_o = rdata_reg;

endmodule
`default_nettype wire

// File: tb/tb_gpio_mmio_port.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_gpio_mmio_port                                         |
// | Description : Directed and randomized bench for gpio_mmio_port with a   |
// |               sample-history reference model.                           |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module tb_gpio_mmio_port;

   localparam int WIDTH = 8;
   localparam int DEB   = 4;
   localparam int HLEN  = DEB + 3;

   logic             clk;
   logic             reset;
   logic [1:0]       addr;
   logic             we;
   logic             re;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic [WIDTH-1:0] gpio_in;
   logic [WIDTH-1:0] gpio_out;
   logic             irq;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [WIDTH-1:0] hist[$];
   logic [WIDTH-1:0] m_out, m_mask, m_edge, m_in;
   logic             m_irq;
   logic [31:0]      m_rdata;

   gpio_mmio_port #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .addr_i  (addr),
      .we_i    (we),
      .re_i    (re),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .GPIO_i  (gpio_in),
      .GPIO_o  (gpio_out),
      .irq_o   (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: IN accepts the sample taken two edges ago once the last DEB+1
   // samples agree; everything else follows the register-map rules.
   task automatic model_edge();
      logic [WIDTH-1:0] new_in, rise, clr;
      logic             all_eq;
      if (reset) begin
         hist.delete();
         for (int i = 0; i < HLEN; i++) hist.push_back('0);
         m_out = '0; m_mask = '0; m_edge = '0; m_in = '0;
         m_irq = 1'b0; m_rdata = '0;
      end else begin
         hist.push_back(gpio_in);
         if (hist.size() > HLEN) void'(hist.pop_front());
         all_eq = 1'b1;
         for (int i = 1; i <= DEB; i++) if (hist[i] !== hist[0]) all_eq = 1'b0;
         new_in = all_eq ? hist[DEB] : m_in;
         rise   = new_in & ~m_in;
         if (re) begin
            case (addr)
               2'd0: m_rdata = 32'(m_out);
               2'd1: m_rdata = 32'(m_in);
               2'd2: m_rdata = 32'(m_edge);
               default: m_rdata = 32'(m_mask);
            endcase
         end
         m_irq = |(m_edge & m_mask);
         clr = (we && addr == 2'd2) ? wdata[WIDTH-1:0] : '0;
         if (we && addr == 2'd0) m_out  = wdata[WIDTH-1:0];
         if (we && addr == 2'd3) m_mask = wdata[WIDTH-1:0];
         m_edge = (m_edge & ~clr) | rise;
         m_in   = new_in;
      end
   endtask

   // One clock: advance the model on the edge, compare all outputs after it.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("gpio_o", 32'(gpio_out), 32'(m_out));
      chk("irq_o", 32'(irq), 32'(m_irq));
      chk("rdata_o", rdata, m_rdata);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a);
      addr = a; re = 1'b1;
      step();
      re = 1'b0;
   endtask

   initial begin
      int first;
      logic found;
      reset = 1'b1; addr = '0; we = 1'b0; re = 1'b0; wdata = '0; gpio_in = '0;

      // reset state
      idle(2);
      reset = 1'b0;
      chk("rst_gpio_o", 32'(gpio_out), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_rdata", rdata, 32'h0);

      // OUT write/read
      wr(2'd0, 32'h0000_00A5);
      chk("out_gpio", 32'(gpio_out), 32'hA5);
      rd(2'd0);
      chk("out_read", rdata, 32'h0000_00A5);

      // IN is read-only; EDGE and MASK read zero after reset
      wr(2'd1, 32'h55);
      rd(2'd1);
      chk("in_ro", rdata, 32'h0);
      rd(2'd2);
      chk("edge_rst", rdata, 32'h0);
      rd(2'd3);
      chk("mask_rst", rdata, 32'h0);

      // accept 0x00->0x01: IN changes DEB+2 edges after the first sampling
      // edge, plus one edge of read latency
      gpio_in = 8'h01; addr = 2'd1; re = 1'b1; found = 1'b0; first = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (!found && rdata[7:0] == 8'h01) begin found = 1'b1; first = k; end
      end
      re = 1'b0;
      chk("in_latency", 32'(first), 32'(DEB + 4));
      rd(2'd2);
      chk("edge_set", rdata, 32'h01);

      // 3-cycle glitch on bit 1 must be rejected
      gpio_in = 8'h03; idle(3);
      gpio_in = 8'h01; idle(10);
      rd(2'd1);
      chk("glitch_in", rdata, 32'h01);
      rd(2'd2);
      chk("glitch_edge", rdata, 32'h01);

      // interrupt: set mask, new rising edge, then clear
      wr(2'd2, 32'hFF);
      wr(2'd3, 32'h01);
      gpio_in = 8'h00; idle(10);
      gpio_in = 8'h01; idle(10);
      chk("irq_set", 32'(irq), 32'h1);
      wr(2'd2, 32'h01);
      chk("irq_hold", 32'(irq), 32'h1);
      step();
      chk("irq_clr", 32'(irq), 32'h0);

      // clear coincides with the edge that accepts a new bit-0 rise
      gpio_in = 8'h00; idle(10);
      gpio_in = 8'h01; idle(DEB + 2);
      wr(2'd2, 32'h01);
      rd(2'd2);
      chk("set_wins", rdata, 32'h01);

      // reset with OUT/MASK/EDGE populated, strobes during reset ignored
      wr(2'd0, 32'hFF);
      wr(2'd3, 32'hFF);
      gpio_in = 8'h0F; idle(10);
      rd(2'd2);
      chk("edge_0f", rdata, 32'h0F);
      gpio_in = 8'h80; reset = 1'b1;
      addr = 2'd0; wdata = 32'hFF; we = 1'b1; re = 1'b1;
      idle(3);
      we = 1'b0; re = 1'b0;
      chk("rst2_gpio_o", 32'(gpio_out), 32'h0);
      chk("rst2_irq", 32'(irq), 32'h0);
      chk("rst2_rdata", rdata, 32'h0);
      reset = 1'b0;
      idle(DEB + 3);
      rd(2'd1);
      chk("rel_in", rdata, 32'h80);
      rd(2'd2);
      chk("rel_edge", rdata, 32'h80);
      rd(2'd3);
      chk("rel_mask", rdata, 32'h0);

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) gpio_in = WIDTH'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         we    = ($urandom_range(0, 2) == 0);
         re    = ($urandom_range(0, 1) == 0);
         addr  = 2'($urandom);
         wdata = $urandom;
         step();
      end
      reset = 1'b0; we = 1'b0; re = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
